// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared defaults and types for the sprite ROM arbiter: requester count,
// ROM geometry and latency.
package sprite_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 13;
   localparam int DEF_DATA_W  = 12;
   localparam int DEF_ROM_LAT = 1;

   typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_id_t;
   typedef logic [DEF_ADDR_W-1:0]          rom_addr_t;
   typedef logic [DEF_DATA_W-1:0]          rom_data_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bundle for the sprite ROM arbiter. The master side is the
// requesters plus the ROM data return; the slave side is the arbiter.
interface sprite_rom_arbiter_if
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W
);

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]             gnt;
   logic [ADDR_W-1:0]              rom_addr;
   logic [DATA_W-1:0]              rom_q;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [DATA_W-1:0]              rsp_data;

   modport master (
      output req, req_addr, rom_q,
      input  gnt, rom_addr, rsp_valid, rsp_data
   );

   modport slave (
      input  req, req_addr, rom_q,
      output gnt, rom_addr, rsp_valid, rsp_data
   );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// searching upward modulo NUM_REQ.
module rr_pick
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         eligible,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic                       found,
   output logic [$clog2(NUM_REQ)-1:0] winner
);

   localparam int ID_W = $clog2(NUM_REQ);

   int idx;

   // NOTE: every output of an always_comb gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM port among NUM_REQ requesters: round-robin issue of one
// read per cycle, with the winner id tracked until its ROM word returns.
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ROM_LAT = DEF_ROM_LAT
) (
   input logic           vga_clk,
   input logic           reset,
   sprite_rom_arbiter_if.slave bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]           eligible;
   logic                         found;
   logic [ID_W-1:0]              winner;
   logic [ID_W-1:0]              rr_ptr;
   logic [ID_W-1:0]              ptr_next;
   logic [NUM_REQ-1:0]           win_onehot;
   logic [NUM_REQ-1:0]           rsp_onehot;
   logic [ROM_LAT:0]             pipe_vld;
   logic [ROM_LAT:0][ID_W-1:0]   pipe_id;

   // A requester just granted sits out one cycle so a held req is a new access.
   assign eligible = bus.req & ~bus.gnt;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .found    (found),
      .winner   (winner)
   );

   always_comb begin
      win_onehot         = '0;
      win_onehot[winner] = 1'b1;
      rsp_onehot                   = '0;
      rsp_onehot[pipe_id[ROM_LAT]] = 1'b1;
      ptr_next = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: the valid/id pipeline is reset along with the outputs; that is what
   // drops in-flight reads when reset hits mid-operation.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         bus.gnt       <= '0;
         bus.rom_addr  <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
         rr_ptr        <= '0;
         pipe_vld      <= '0;
         pipe_id       <= '0;
      end else begin
         if (found) begin
            bus.gnt      <= win_onehot;
            bus.rom_addr <= bus.req_addr[winner];
            rr_ptr       <= ptr_next;
         end else begin
            bus.gnt <= '0;
         end

         // Stage k is valid in cycle G+k; stage ROM_LAT lines up with rom_q.
         pipe_vld <= {pipe_vld[ROM_LAT-1:0], found};
         pipe_id  <= {pipe_id[ROM_LAT-1:0], winner};

         bus.rsp_valid <= pipe_vld[ROM_LAT] ? rsp_onehot : '0;
         if (pipe_vld[ROM_LAT]) bus.rsp_data <= bus.rom_q;
      end
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sprite_rom_arbiter;
   import sprite_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 13;
   localparam int DATA_W  = 12;
   localparam int ROM_LAT = 1;

   logic vga_clk = 1'b0;
   logic reset   = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sprite_rom_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ROM_LAT (ROM_LAT)
   ) dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic rom_data_t rom_fn(input rom_addr_t a);
      return a[11:0] ^ 12'hA5A;
   endfunction

   // ROM with one cycle of read latency.
   initial bus.rom_q = '0;
   always @(posedge vga_clk) bus.rom_q <= rom_fn(bus.rom_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      int        due;
      int        id;
      rom_data_t data;
   } pend_t;

   pend_t            pend[$];
   int               cyc = 0;
   int               mdl_w;
   int               mdl_k;
   logic [3:0]       mdl_elig;
   logic [3:0]       mdl_gnt       = '0;
   rom_addr_t        mdl_addr      = '0;
   int               mdl_ptr       = 0;
   logic [3:0]       mdl_rsp_valid = '0;
   rom_data_t        mdl_rsp_data  = '0;

   always @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         mdl_gnt       = '0;
         mdl_addr      = '0;
         mdl_ptr       = 0;
         mdl_rsp_valid = '0;
         mdl_rsp_data  = '0;
         cyc           = 0;
         pend.delete();
      end else begin
         cyc++;
         mdl_elig = bus.req & ~mdl_gnt;
         mdl_w    = -1;
         for (int i = 0; i < NUM_REQ; i++) begin
            mdl_k = (mdl_ptr + i) % NUM_REQ;
            if (mdl_w < 0 && mdl_elig[mdl_k]) mdl_w = mdl_k;
         end
         if (mdl_w >= 0) begin
            mdl_gnt  = 4'(1 << mdl_w);
            mdl_addr = bus.req_addr[mdl_w];
            mdl_ptr  = (mdl_w + 1) % NUM_REQ;
            pend.push_back('{due: cyc + ROM_LAT + 1, id: mdl_w, data: rom_fn(bus.req_addr[mdl_w])});
         end else begin
            mdl_gnt = '0;
         end
         mdl_rsp_valid = '0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            mdl_rsp_valid = 4'(1 << pend[0].id);
            mdl_rsp_data  = pend[0].data;
            void'(pend.pop_front());
         end
      end
   end

   always @(negedge vga_clk) begin
      check("cmp_gnt",       32'(bus.gnt),       32'(mdl_gnt));
      check("cmp_rom_addr",  32'(bus.rom_addr),  32'(mdl_addr));
      check("cmp_rsp_valid", 32'(bus.rsp_valid), 32'(mdl_rsp_valid));
      check("cmp_rsp_data",  32'(bus.rsp_data),  32'(mdl_rsp_data));
   end

   // ---------------- directed scenarios ----------------
   task automatic do_reset();
      @(negedge vga_clk);
      bus.req = '0;
      #1 reset = 1'b1;
      @(negedge vga_clk);
      @(negedge vga_clk);
      #1 reset = 1'b0;
   endtask

   logic [3:0]  exp_v;
   rom_addr_t   addrs [4];
   rom_data_t   datas [4];
   int          n_gr;
   int          n_consec;
   logic        prev_g;
   rom_addr_t   held_addr;
   rom_data_t   held_data;

   initial begin
      bus.req      = '0;
      bus.req_addr = '0;
      #2 reset = 1'b1;

      // Reset state
      @(negedge vga_clk);
      check("rst_gnt",       32'(bus.gnt),       32'h0);
      check("rst_rom_addr",  32'(bus.rom_addr),  32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_data",  32'(bus.rsp_data),  32'h0);
      @(negedge vga_clk);
      #1 reset = 1'b0;

      // Single pulse on req[2]
      @(negedge vga_clk);
      bus.req         = 4'b0100;
      bus.req_addr[2] = 13'h0100;
      @(negedge vga_clk);
      check("single_gnt",      32'(bus.gnt),      32'h4);
      check("single_rom_addr", 32'(bus.rom_addr), 32'h0100);
      bus.req = '0;
      @(negedge vga_clk);
      check("single_rsp_early", 32'(bus.rsp_valid), 32'h0);
      @(negedge vga_clk);
      check("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      check("single_rsp_data",  32'(bus.rsp_data),  32'hB5A);
      @(negedge vga_clk);
      check("single_rsp_once", 32'(bus.rsp_valid), 32'h0);
      check("single_rsp_hold", 32'(bus.rsp_data),  32'hB5A);

      // Idle for 10 cycles: outputs quiet, address and data held
      held_addr = bus.rom_addr;
      held_data = bus.rsp_data;
      for (int j = 0; j < 10; j++) begin
         @(negedge vga_clk);
         check("idle_gnt",       32'(bus.gnt),       32'h0);
         check("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
         check("idle_rom_addr",  32'(bus.rom_addr),  32'(held_addr));
         check("idle_rsp_data",  32'(bus.rsp_data),  32'(held_data));
      end

      // All four requesting for 8 cycles
      do_reset();
      addrs = '{13'h0200, 13'h0211, 13'h0222, 13'h0233};
      datas = '{12'h85A, 12'h84B, 12'h878, 12'h869};
      for (int i = 0; i < 4; i++) bus.req_addr[i] = addrs[i];
      @(negedge vga_clk);
      bus.req = 4'b1111;
      for (int j = 0; j < 10; j++) begin
         @(negedge vga_clk);
         if (j < 8) begin
            exp_v = 4'(1 << (j % 4));
            check("rr_gnt",      32'(bus.gnt),      32'(exp_v));
            check("rr_rom_addr", 32'(bus.rom_addr), 32'(addrs[j % 4]));
         end
         if (j >= 2) begin
            exp_v = 4'(1 << ((j - 2) % 4));
            check("rr_rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
            check("rr_rsp_data",  32'(bus.rsp_data),  32'(datas[(j - 2) % 4]));
         end
         if (j == 7) bus.req = '0;
      end

      // Single requester held: alternate-cycle grants only
      do_reset();
      @(negedge vga_clk);
      bus.req  = 4'b0010;
      n_gr     = 0;
      n_consec = 0;
      prev_g   = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(negedge vga_clk);
         if (bus.gnt[1] === 1'b1) begin
            n_gr++;
            if (prev_g) n_consec++;
         end
         prev_g = (bus.gnt[1] === 1'b1);
      end
      bus.req = '0;
      check("hold_grant_count",  32'(n_gr),     32'd3);
      check("hold_back_to_back", 32'(n_consec), 32'd0);

      // Pointer wrap: grant 3, then 0 and 3 compete
      do_reset();
      @(negedge vga_clk);
      bus.req = 4'b1000;
      @(negedge vga_clk);
      check("wrap_first", 32'(bus.gnt), 32'h8);
      bus.req = '0;
      @(negedge vga_clk);
      bus.req = 4'b1001;
      @(negedge vga_clk);
      check("wrap_to_zero", 32'(bus.gnt), 32'h1);
      @(negedge vga_clk);
      check("wrap_then_three", 32'(bus.gnt), 32'h8);
      bus.req = '0;
      @(negedge vga_clk);
      @(negedge vga_clk);
      @(negedge vga_clk);

      // Reset with a read in flight
      bus.req         = 4'b0010;
      bus.req_addr[1] = 13'h0345;
      @(negedge vga_clk);
      check("mid_gnt", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      @(posedge vga_clk);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_gnt",       32'(bus.gnt),       32'h0);
      check("mid_rst_rom_addr",  32'(bus.rom_addr),  32'h0);
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("mid_rst_rsp_data",  32'(bus.rsp_data),  32'h0);
      @(negedge vga_clk);
      @(negedge vga_clk);
      #1 reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge vga_clk);
         check("mid_no_rsp", 32'(bus.rsp_valid), 32'h0);
      end
      bus.req = 4'b1010;
      @(negedge vga_clk);
      check("mid_lowest_first", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      repeat (4) @(negedge vga_clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
